// File: rtl/commit_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : commit_sequencer_pkg
//  Brief    : Shared constants and types for the in-order commit sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package commit_sequencer_pkg;

    typedef enum logic [1:0] {
        CS_IDLE       = 2'd0,
        CS_WAIT_STORE = 2'd1,
        CS_FLUSH      = 2'd2
    } cs_state_e;

    localparam int ROB_POS_W = 4;

    typedef logic [4:0]           REG_POS_TYPE;
    typedef logic [ROB_POS_W-1:0] ROB_POS_TYPE;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam ROB_POS_TYPE ZERO_ROB  = '0;
    localparam REG_POS_TYPE ZERO_REG  = 5'd0;

endpackage : commit_sequencer_pkg
`default_nettype wire

// File: rtl/commit_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : commit_sequencer
//  Brief    : In-order retirement controller: ROB head -> regfile commit port,
//             store release to LSB, mispredict flush and fetch redirect.
//             Optional macro CXK_INSTRET_EN adds a 64-bit retired-entry counter.
//  Revision : 1.0  initial release
// ============================================================================
module commit_sequencer
    import commit_sequencer_pkg::*;
#(
    parameter int ROB_W        = ROB_POS_W,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             in_rob_valid,
    output logic             out_rob_ready,
    input  logic [ROB_W-1:0] in_rob_tag,
    input  logic [4:0]       in_rob_dest_reg,
    input  logic [31:0]      in_rob_value,
    input  logic             in_rob_is_store,
    input  logic             in_rob_mispredict,
    input  logic [31:0]      in_rob_target_pc,
    output logic [4:0]       out_commit_reg,
    output logic [ROB_W-1:0] out_commit_rob,
    output logic [31:0]      out_commit_value,
    output logic             out_xbp,
    output logic             out_redirect_valid,
    output logic [31:0]      out_redirect_pc,
    output logic             out_store_commit,
`ifdef CXK_INSTRET_EN
    output logic [63:0]      out_instret,
`endif
    input  logic             in_lsb_store_done
);

    localparam int              c_cnt_w      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_flush_load = c_cnt_w'(FLUSH_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    cs_state_e          r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    REG_POS_TYPE        r_commit_reg, w_commit_reg_nxt;
    logic [ROB_W-1:0]   r_commit_rob, w_commit_rob_nxt;
    logic [31:0]        r_commit_value, w_commit_value_nxt;
    logic               r_xbp, w_xbp_nxt;
    logic               r_redir_valid, w_redir_valid_nxt;
    logic [31:0]        r_redir_pc, w_redir_pc_nxt;
    logic               r_store_commit, w_store_commit_nxt;
    logic               w_ready;
    logic               w_pop;

    assign w_ready = (r_state == CS_IDLE) && rdy && !rst;
    assign w_pop   = in_rob_valid && w_ready;

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_commit_reg_nxt   = ZERO_REG;
        w_commit_rob_nxt   = r_commit_rob;
        w_commit_value_nxt = r_commit_value;
        w_xbp_nxt          = 1'b0;
        w_redir_valid_nxt  = 1'b0;
        w_redir_pc_nxt     = r_redir_pc;
        w_store_commit_nxt = 1'b0;
        case (r_state)
            CS_IDLE: begin
                if (w_pop) begin
                    if (in_rob_is_store) begin
                        w_store_commit_nxt = 1'b1;
                        w_state_nxt        = CS_WAIT_STORE;
                    end else begin
                        // A mispredicted JAL/JALR still writes its link register.
                        w_commit_reg_nxt   = in_rob_dest_reg;
                        w_commit_rob_nxt   = in_rob_tag;
                        w_commit_value_nxt = in_rob_value;
                        if (in_rob_mispredict) begin
                            w_xbp_nxt         = 1'b1;
                            w_redir_valid_nxt = 1'b1;
                            w_redir_pc_nxt    = in_rob_target_pc;
                            w_cnt_nxt         = c_flush_load;
                            if (FLUSH_CYCLES > 1) begin
                                w_state_nxt = CS_FLUSH;
                            end
                        end
                    end
                end
            end
            CS_WAIT_STORE: begin
                if (in_lsb_store_done) begin
                    w_state_nxt = CS_IDLE;
                end
            end
            CS_FLUSH: begin
                w_cnt_nxt = r_cnt - c_cnt_one;
                if (r_cnt <= c_cnt_one) begin
                    w_state_nxt = CS_IDLE;
                end
            end
            default: begin
                w_state_nxt = CS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= CS_IDLE;
            r_cnt          <= '0;
            r_commit_reg   <= ZERO_REG;
            r_commit_rob   <= '0;
            r_commit_value <= ZERO_WORD;
            r_xbp          <= 1'b0;
            r_redir_valid  <= 1'b0;
            r_redir_pc     <= ZERO_WORD;
            r_store_commit <= 1'b0;
        end else if (rdy) begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_commit_reg   <= w_commit_reg_nxt;
            r_commit_rob   <= w_commit_rob_nxt;
            r_commit_value <= w_commit_value_nxt;
            r_xbp          <= w_xbp_nxt;
            r_redir_valid  <= w_redir_valid_nxt;
            r_redir_pc     <= w_redir_pc_nxt;
            r_store_commit <= w_store_commit_nxt;
        end
    end

`ifdef CXK_INSTRET_EN
    logic [63:0] r_instret;

    // w_pop already implies rdy, so the count freezes with the rest of the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= 64'd0;
        end else if (w_pop) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign out_instret = r_instret;
`endif

    assign out_rob_ready      = w_ready;
    assign out_commit_reg     = r_commit_reg;
    assign out_commit_rob     = r_commit_rob;
    assign out_commit_value   = r_commit_value;
    assign out_xbp            = r_xbp;
    assign out_redirect_valid = r_redir_valid;
    assign out_redirect_pc    = r_redir_pc;
    assign out_store_commit   = r_store_commit;

endmodule : commit_sequencer
`default_nettype wire
